// File: rtl/xg_pkt_gen.sv
// rtl/xg_pkt_gen.sv - 10G Ethernet test-frame generator driving a 64-bit TX AXI-Stream.
module xg_pkt_gen #(
  parameter int          C_M_AXIS_DATA_WIDTH  = 64,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] C_ETHERTYPE          = 16'h88B5
) (
  input  logic                              axi_aclk,
  input  logic                              reset,
  input  logic                              link_ready,
  input  logic                              start,
  input  logic                              stop,
  input  logic [13:0]                       pkt_len,
  input  logic [31:0]                       pkt_count,
  input  logic [15:0]                       ifg_cycles,
  input  logic [47:0]                       dst_mac,
  input  logic [47:0]                       src_mac,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       tx_pkt_cnt,
  output logic [47:0]                       tx_byte_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]  state;
  logic [13:0] len_q;
  logic [31:0] cnt_q;
  logic [15:0] ifg_q;
  logic [47:0] dst_q;
  logic [47:0] src_q;
  logic [31:0] seq_q;
  logic [10:0] beat_idx;
  logic [15:0] gap_cnt;
  logic        stop_pend;

  logic [13:0] len_in;
  logic [13:0] ld_len;
  logic [47:0] ld_dst;
  logic [47:0] ld_src;
  logic [31:0] ld_seq;
  logic [10:0] ld_idx;
  logic [63:0] nxt_data;
  logic [7:0]  nxt_keep;
  logic        nxt_last;
  logic        hs;
  logic        run_end;

  function automatic logic [10:0] last_idx(input logic [13:0] len);
    logic [13:0] nb;
    nb = (len + 14'd7) >> 3;
    return 11'(nb - 14'd1);
  endfunction

  // Byte k of the frame: MAC header, EtherType, big-endian sequence, then k[7:0].
  function automatic logic [63:0] beat_data(input logic [10:0] idx, input logic [13:0] len,
                                            input logic [47:0] dst, input logic [47:0] src,
                                            input logic [31:0] seq);
    logic [63:0] d;
    logic [13:0] k;
    int          ki;
    d = '0;
    for (int n = 0; n < 8; n++) begin
      k  = {idx, 3'b000} + 14'(n);
      ki = int'(k);
      if (k < len) begin
        if (ki < 6)        d[8*n +: 8] = dst[8*(5-ki) +: 8];
        else if (ki < 12)  d[8*n +: 8] = src[8*(11-ki) +: 8];
        else if (ki == 12) d[8*n +: 8] = C_ETHERTYPE[15:8];
        else if (ki == 13) d[8*n +: 8] = C_ETHERTYPE[7:0];
        else if (ki < 18)  d[8*n +: 8] = seq[8*(17-ki) +: 8];
        else               d[8*n +: 8] = k[7:0];
      end
    end
    return d;
  endfunction

  function automatic logic [7:0] beat_keep(input logic [10:0] idx, input logic [13:0] len);
    if (idx == last_idx(len) && len[2:0] != 3'd0)
      return 8'hFF >> (4'd8 - {1'b0, len[2:0]});
    return 8'hFF;
  endfunction

  assign len_in = (pkt_len < 14'd60)   ? 14'd60 :
                  (pkt_len > 14'd9600) ? 14'd9600 : pkt_len;
  assign hs     = m_axis_tvalid && m_axis_tready;
  assign run_end = stop_pend || stop || (cnt_q != 32'd0 && tx_pkt_cnt + 32'd1 == cnt_q);

  // Selects which beat gets loaded into the output registers this cycle.
  always_comb begin
    ld_len = len_q;
    ld_dst = dst_q;
    ld_src = src_q;
    ld_seq = seq_q;
    ld_idx = 11'd0;
    if (state == ST_IDLE) begin
      ld_len = len_in;
      ld_dst = dst_mac;
      ld_src = src_mac;
      ld_seq = 32'd0;
    end else if (state == ST_SEND) begin
      if (m_axis_tlast) ld_seq = seq_q + 32'd1;
      else              ld_idx = beat_idx + 11'd1;
    end
    nxt_data = beat_data(ld_idx, ld_len, ld_dst, ld_src, ld_seq);
    nxt_keep = beat_keep(ld_idx, ld_len);
    nxt_last = (ld_idx == last_idx(ld_len));
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      cnt_q         <= '0;
      ifg_q         <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      seq_q         <= '0;
      beat_idx      <= '0;
      gap_cnt       <= '0;
      stop_pend     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tx_pkt_cnt    <= '0;
      tx_byte_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && link_ready) begin
            len_q             <= len_in;
            cnt_q             <= pkt_count;
            ifg_q             <= ifg_cycles;
            dst_q             <= dst_mac;
            src_q             <= src_mac;
            seq_q             <= '0;
            beat_idx          <= '0;
            stop_pend         <= 1'b0;
            tx_pkt_cnt        <= '0;
            tx_byte_cnt       <= '0;
            busy              <= 1'b1;
            state             <= ST_SEND;
            m_axis_tvalid     <= 1'b1;
            m_axis_tdata      <= nxt_data;
            m_axis_tkeep      <= nxt_keep;
            m_axis_tlast      <= nxt_last;
            m_axis_tuser      <= '0;
            m_axis_tuser[15:0] <= {2'b00, len_in};
          end
        end
        ST_SEND: begin
          if (stop) stop_pend <= 1'b1;
          if (hs) begin
            if (m_axis_tlast) begin
              tx_pkt_cnt  <= tx_pkt_cnt + 32'd1;
              tx_byte_cnt <= tx_byte_cnt + 48'(len_q);
              seq_q       <= seq_q + 32'd1;
              beat_idx    <= '0;
              if (run_end) begin
                state         <= ST_IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
              end else if (ifg_q != 16'd0) begin
                state         <= ST_GAP;
                gap_cnt       <= ifg_q;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
              end else begin
                m_axis_tdata <= nxt_data;
                m_axis_tkeep <= nxt_keep;
                m_axis_tlast <= nxt_last;
              end
            end else begin
              beat_idx     <= beat_idx + 11'd1;
              m_axis_tdata <= nxt_data;
              m_axis_tkeep <= nxt_keep;
              m_axis_tlast <= nxt_last;
            end
          end
        end
        ST_GAP: begin
          if (stop || stop_pend) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (gap_cnt == 16'd1) begin
            state         <= ST_SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= nxt_data;
            m_axis_tkeep  <= nxt_keep;
            m_axis_tlast  <= nxt_last;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xg_pkt_gen.sv
// tb/tb_xg_pkt_gen.sv - scoreboard bench for xg_pkt_gen.
module tb_xg_pkt_gen;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [15:0] u;
  } beat_t;

  logic         axi_aclk = 1'b0;
  logic         reset;
  logic         link_ready;
  logic         start;
  logic         stop;
  logic [13:0]  pkt_len;
  logic [31:0]  pkt_count;
  logic [15:0]  ifg_cycles;
  logic [47:0]  dst_mac;
  logic [47:0]  src_mac;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [127:0] m_axis_tuser;
  logic         busy;
  logic         done;
  logic [31:0]  tx_pkt_cnt;
  logic [47:0]  tx_byte_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_mode = 0;

  beat_t       exp_q[$];
  logic [63:0] cap_q[$];
  int          beats_q[$];
  int          gaps_q[$];
  int          frames_seen = 0;
  int          beat_in_frame = 0;
  int          tlast_cyc = 0;
  logic [7:0]  last_keep = '0;
  bit          in_gap = 0;
  int          gap = 0;
  bit          held_v = 0;
  logic [88:0] held;

  xg_pkt_gen dut (
    .axi_aclk      (axi_aclk),
    .reset         (reset),
    .link_ready    (link_ready),
    .start         (start),
    .stop          (stop),
    .pkt_len       (pkt_len),
    .pkt_count     (pkt_count),
    .ifg_cycles    (ifg_cycles),
    .dst_mac       (dst_mac),
    .src_mac       (src_mac),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .done          (done),
    .tx_pkt_cnt    (tx_pkt_cnt),
    .tx_byte_cnt   (tx_byte_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;
  always @(posedge axi_aclk) cyc <= cyc + 1;

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge axi_aclk);
      #1;
      m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference frame: header bytes taken MSB-first from a packed vector, payload byte k = k[7:0].
  task automatic push_frame(input int len_req, input logic [31:0] seq);
    int           len;
    int           nb;
    int           k;
    logic [143:0] hdr;
    beat_t        e;
    len = (len_req < 60) ? 60 : (len_req > 9600) ? 9600 : len_req;
    hdr = {dst_mac, src_mac, 16'h88B5, seq};
    nb  = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int n = 0; n < 8; n++) begin
        k = b * 8 + n;
        if (k < len) begin
          e.k[n] = 1'b1;
          if (k < 18) e.d[8*n +: 8] = hdr[143 - 8*k -: 8];
          else        e.d[8*n +: 8] = 8'(k);
        end
      end
      e.l = (b == nb - 1);
      e.u = 16'(len);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge axi_aclk) begin
    if (reset) begin
      held_v = 0;
      in_gap = 0;
    end else begin
      if (held_v)
        chk("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser[15:0]},
            {1'b1, held});
      held_v = m_axis_tvalid && !m_axis_tready;
      held   = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser[15:0]};
      if (m_axis_tvalid && in_gap) begin
        gaps_q.push_back(gap);
        in_gap = 0;
      end else if (!m_axis_tvalid && in_gap) begin
        gap++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {m_axis_tdata, m_axis_tkeep}, '0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, {e.d, e.k, e.l, 112'd0, e.u});
        end
        cap_q.push_back(m_axis_tdata);
        beat_in_frame++;
        if (m_axis_tlast) begin
          beats_q.push_back(beat_in_frame);
          last_keep     = m_axis_tkeep;
          beat_in_frame = 0;
          frames_seen++;
          tlast_cyc = cyc;
          in_gap    = 1;
          gap       = 0;
        end
      end
    end
  end

  task automatic clr_mon();
    exp_q.delete();
    cap_q.delete();
    beats_q.delete();
    gaps_q.delete();
    frames_seen   = 0;
    beat_in_frame = 0;
    in_gap        = 0;
  endtask

  task automatic run(input int len, input int cnt, input int ifg);
    @(negedge axi_aclk);
    pkt_len    = 14'(len);
    pkt_count  = 32'(cnt);
    ifg_cycles = 16'(ifg);
    start      = 1'b1;
    @(negedge axi_aclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit got;
    got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge axi_aclk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", 128'(got), 128'd1);
  endtask

  initial begin
    reset = 1'b1; link_ready = 1'b1; start = 1'b0; stop = 1'b0;
    pkt_len = 14'd64; pkt_count = 32'd1; ifg_cycles = 16'd0;
    dst_mac = 48'h001122334455; src_mac = 48'h66778899AABB;
    repeat (3) @(negedge axi_aclk);
    reset = 1'b0;
    @(negedge axi_aclk);
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("rst_tlast", 128'(m_axis_tlast), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_tdata_tkeep", {m_axis_tdata, m_axis_tkeep}, '0);
    chk("rst_tuser", m_axis_tuser, '0);
    chk("rst_counters", {tx_pkt_cnt, tx_byte_cnt}, '0);

    // L=64, one frame, back-to-back
    clr_mon();
    push_frame(64, 0);
    run(64, 1, 0);
    chk("t1_busy", 128'(busy), 128'd1);
    wait_done(100);
    chk("t1_done_timing", 128'(cyc), 128'(tlast_cyc + 1));
    chk("t1_busy_end", 128'(busy), 128'd0);
    chk("t1_pkt_cnt", 128'(tx_pkt_cnt), 128'd1);
    chk("t1_byte_cnt", 128'(tx_byte_cnt), 128'd64);
    chk("t1_beats", 128'(cap_q.size()), 128'd8);
    if (cap_q.size() >= 3) begin
      chk("t1_beat0", 128'(cap_q[0]), 128'(64'h7766554433221100));
      chk("t1_beat1", 128'(cap_q[1]), 128'(64'h0000B588BBAA9988));
      chk("t1_beat2", 128'(cap_q[2]), 128'(64'h1716151413120000));
    end
    chk("t1_last_keep", 128'(last_keep), 128'h0FF);
    @(negedge axi_aclk);
    chk("t1_done_pulse", 128'(done), 128'd0);

    // L=61, three frames, 4-cycle gap
    clr_mon();
    for (int f = 0; f < 3; f++) push_frame(61, 32'(f));
    run(61, 3, 4);
    wait_done(300);
    chk("t2_pkt_cnt", 128'(tx_pkt_cnt), 128'd3);
    chk("t2_byte_cnt", 128'(tx_byte_cnt), 128'd183);
    chk("t2_last_keep", 128'(last_keep), 128'h1F);
    chk("t2_num_gaps", 128'(gaps_q.size()), 128'd2);
    foreach (gaps_q[i]) chk("t2_gap", 128'(gaps_q[i]), 128'd4);
    foreach (beats_q[i]) chk("t2_beats", 128'(beats_q[i]), 128'd8);
    chk("t2_queue_empty", 128'(exp_q.size()), 128'd0);

    // L=1500, five frames, random backpressure
    clr_mon();
    for (int f = 0; f < 5; f++) push_frame(1500, 32'(f));
    rand_mode = 1;
    run(1500, 5, 0);
    wait_done(6000);
    rand_mode = 0;
    chk("t3_pkt_cnt", 128'(tx_pkt_cnt), 128'd5);
    chk("t3_byte_cnt", 128'(tx_byte_cnt), 128'd7500);
    chk("t3_frames", 128'(beats_q.size()), 128'd5);
    foreach (beats_q[i]) chk("t3_beats", 128'(beats_q[i]), 128'd188);
    chk("t3_queue_empty", 128'(exp_q.size()), 128'd0);

    // continuous run, stop pulsed during frame 2
    clr_mon();
    for (int f = 0; f < 3; f++) push_frame(64, 32'(f));
    run(64, 0, 0);
    begin
      int i;
      i = 0;
      while (!(frames_seen == 2 && beat_in_frame >= 3) && i < 200) begin
        @(posedge axi_aclk);
        #2;
        i++;
      end
      chk("t4_reach_frame2", 128'(i < 200), 128'd1);
    end
    stop = 1'b1;
    @(posedge axi_aclk);
    #2;
    stop = 1'b0;
    wait_done(100);
    chk("t4_pkt_cnt", 128'(tx_pkt_cnt), 128'd3);
    chk("t4_byte_cnt", 128'(tx_byte_cnt), 128'd192);
    repeat (20) @(negedge axi_aclk);
    chk("t4_no_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("t4_queue_empty", 128'(exp_q.size()), 128'd0);

    // length clamping
    clr_mon();
    push_frame(20, 0);
    run(20, 1, 0);
    wait_done(100);
    chk("t5_min_bytes", 128'(tx_byte_cnt), 128'd60);
    chk("t5_min_keep", 128'(last_keep), 128'h0F);
    chk("t5_min_tuser", 128'(m_axis_tuser[15:0]), 128'd60);
    clr_mon();
    push_frame(12000, 0);
    run(12000, 1, 0);
    wait_done(2000);
    chk("t5_max_bytes", 128'(tx_byte_cnt), 128'd9600);
    chk("t5_max_tuser", 128'(m_axis_tuser[15:0]), 128'd9600);
    if (beats_q.size() > 0) chk("t5_max_beats", 128'(beats_q[0]), 128'd1200);

    // start ignored without link
    clr_mon();
    link_ready = 1'b0;
    run(64, 1, 0);
    repeat (10) @(negedge axi_aclk);
    chk("t6_no_busy", 128'(busy), 128'd0);
    chk("t6_no_tvalid", 128'(m_axis_tvalid), 128'd0);
    link_ready = 1'b1;

    // reset in the middle of the second frame
    clr_mon();
    for (int f = 0; f < 3; f++) push_frame(64, 32'(f));
    run(64, 3, 0);
    begin
      int i;
      i = 0;
      while (!(frames_seen >= 1 && beat_in_frame >= 2) && i < 200) begin
        @(posedge axi_aclk);
        #2;
        i++;
      end
      chk("t7_reach_frame1", 128'(i < 200), 128'd1);
    end
    @(negedge axi_aclk);
    reset = 1'b1;
    @(posedge axi_aclk);
    #1;
    chk("t7_rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("t7_rst_tlast", 128'(m_axis_tlast), 128'd0);
    chk("t7_rst_counters", {tx_pkt_cnt, tx_byte_cnt, 31'd0, busy}, '0);
    @(negedge axi_aclk);
    reset = 1'b0;
    clr_mon();
    push_frame(64, 0);
    run(64, 1, 0);
    wait_done(100);
    chk("t7_pkt_cnt", 128'(tx_pkt_cnt), 128'd1);
    chk("t7_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
